crc8_frame_ctrl: RTL and testbench
==================================

# crc8_frame_ctrl

Byte-stream front end for the team's serial CRC-8 shifter. Accepts bytes over a valid/ready handshake and serialises each one into the shifter, one bit per cycle. At end of frame it presents the 8-bit CRC on a held valid/ready output. It sits between a byte-wide packet source and the frame-check insertion/compare logic, and it owns the shifter's init, shift and bit inputs.

## Interface
- `MSB_FIRST`, default 1: bit order within a byte; 1 = bit 7 first, 0 = bit 0 first.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: controller can accept a byte.
- `s_data` in 8: input byte.
- `s_last` in 1: byte is the final byte of the frame.
- `abort` in 1: drop the current frame; synchronous.
- `crc_valid` out 1: CRC result available.
- `crc_ready` in 1: consumer takes the result.
- `crc_data` out 8: CRC result.
- `busy` out 1: high in every state except IDLE.

## Operation
- CRC: polynomial x^8+x^6+x^5+x^3+1, init 0xFF, no final XOR.
- Shift update: `c' = {c[6:0], bit} ^ (c[7] ? 8'h69 : 0)`.
- FSM states: IDLE, SHIFT, AUG (only with the macro), DONE.
- IDLE:
  - `s_ready` = 1.
  - On `s_valid & s_ready`: capture `s_data` and `s_last`, re-init the CRC to 0xFF on the same edge, clear `bit_cnt`, go to SHIFT.
- SHIFT:
  - Shifter `shift` = 1 every cycle.
  - `bit` = captured byte bit, selected by `MSB_FIRST` and `bit_cnt` (3-bit, counts 0..7).
  - `s_ready` = 1 only when `bit_cnt == 7` and the captured `last == 0`.
- End of a byte, at `bit_cnt == 7`:
  - If `last` = 1: go to AUG (macro defined) or DONE (macro undefined).
  - Else, if a byte is accepted this cycle: capture it, wrap `bit_cnt` to 0, stay in SHIFT. No CRC re-init.
  - Else: go to a between-byte wait. This is SHIFT with `shift` = 0 and `s_ready` = 1; it continues as soon as a byte arrives.
- DONE:
  - `crc_valid` = 1; `crc_data` = the CRC register, held stable.
  - On `crc_ready`: go to IDLE.
  - `s_ready` = 0.
- `abort`, in any state: go to IDLE, no shift this cycle, `crc_valid` drops, CRC left as is (re-init happens at the next frame start). `abort` has priority over every handshake in the same cycle.
- `rst`, including mid-frame: state IDLE, CRC register 0xFF, `bit_cnt` 0.

## Timing
- Reset values of outputs: `s_ready` = 1, `crc_valid` = 0, `crc_data` = 0xFF, `busy` = 0.
- A byte accepted in cycle T is shifted on edges T+1..T+8.
- Back-to-back throughput: 8 cycles per byte. The next byte can be accepted in cycle T+8.
- Last byte accepted in cycle T: `crc_valid` rises in cycle T+9, or T+17 with the macro.
- `crc_valid` is held with `crc_data` constant until the cycle in which `crc_ready` = 1.
- A new frame can be accepted in the cycle after the result handshake.
- Zero-length frames are not supported. `s_last` qualifies a data byte only.

## Configuration
- Macro `CRC8_FRAME_AUGMENT_EN`.
- Defined: after the last byte, AUG state shifts 8 zero bits (`shift` = 1, `bit` = 0, `s_ready` = 0). The result is the conventional message·x^8 remainder.
- Undefined: AUG state, its counter reuse and its transitions are compiled out. Result = the register value immediately after the last data bit.

## Structure
- Package `crc8_pkg` holds:
  - The state enum.
  - `CRC8_POLY_MASK = 8'h69`.
  - `CRC8_INIT = 8'hFF`.
- One sub-module: the existing `crc8` serial shifter.
  - Its reset is driven by `rst | frame_init`.
  - `shift` and `bit` come from the FSM.
  - `crc_data` is taken directly from its `result`.

## Test plan
- Reset, then frame {0x00}, last = 1, accepted in cycle 0, macro off → `crc_valid` in cycle 9, `crc_data` = 0x26.
- Frame {0x00, 0x00} back-to-back, macro off → second byte accepted in cycle 8, `crc_valid` in cycle 17, `crc_data` = 0x68.
- Frame {0x00}, macro on → `crc_valid` in cycle 17, `crc_data` = 0x68.
- `crc_ready` held low for 5 cycles → `crc_valid` and `crc_data` stable throughout, `s_ready` = 0; IDLE after the handshake.
- `abort` during bit 4 of a byte, then frame {0x00} → second frame yields 0x26 (macro off), i.e. the CRC is re-initialised.
- `rst` asserted mid-SHIFT → next cycle `busy` = 0, `s_ready` = 1, `crc_valid` = 0, `crc_data` = 0xFF.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared types and constants for the CRC-8 frame front end.
// CRC8_FRAME_AUGMENT_EN adds the zero-augmentation state to the FSM encoding.
package crc8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef CRC8_FRAME_AUGMENT_EN
    ST_AUG   = 2'd2,
`endif
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY_MASK = 8'h69;
  localparam logic [7:0] CRC8_INIT      = 8'hFF;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], b} ^ (c[7] ? CRC8_POLY_MASK : 8'h00);
  endfunction

endpackage

// File: rtl/crc8.sv
// Serial CRC-8 shifter: one message bit per enabled cycle, MSB of the register
// feeds back through the polynomial mask. Synchronous reset loads the init value.
module crc8
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift,
  input  logic       crc_bit,
  output logic [7:0] result
);

  logic [7:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst)
      crc_q <= CRC8_INIT;
    else if (shift)
      crc_q <= crc8_step(crc_q, crc_bit);
  end

  assign result = crc_q;

endmodule

// File: rtl/crc8_frame_ctrl.sv
// Byte-stream front end that serialises framed bytes into the crc8 shifter.
// Define CRC8_FRAME_AUGMENT_EN to append eight zero bits after the last byte.
module crc8_frame_ctrl
  import crc8_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       abort,
  output logic       crc_valid,
  input  logic       crc_ready,
  output logic [7:0] crc_data,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       waiting, waiting_nxt;
  logic [7:0] byte_q;
  logic       last_q;
  logic       load, frame_init, shift, crc_bit;
  logic [2:0] bit_idx;

  assign bit_idx = (MSB_FIRST != 0) ? (3'd7 - bit_cnt) : bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      waiting <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      waiting <= waiting_nxt;
    end
  end

  // Byte holding register is pure data and is only written on acceptance.
  always_ff @(posedge clk) begin
    if (load) begin
      byte_q <= s_data;
      last_q <= s_last;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    waiting_nxt = waiting;
    load        = 1'b0;
    frame_init  = 1'b0;
    shift       = 1'b0;
    crc_bit     = 1'b0;
    s_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load        = 1'b1;
          frame_init  = 1'b1;
          bit_cnt_nxt = 3'd0;
          waiting_nxt = 1'b0;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (waiting) begin
          s_ready = 1'b1;
          if (s_valid) begin
            load        = 1'b1;
            bit_cnt_nxt = 3'd0;
            waiting_nxt = 1'b0;
          end
        end else begin
          shift       = 1'b1;
          crc_bit     = byte_q[bit_idx];
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (last_q) begin
`ifdef CRC8_FRAME_AUGMENT_EN
              state_nxt = ST_AUG;
`else
              state_nxt = ST_DONE;
`endif
            end else begin
              s_ready = 1'b1;
              if (s_valid)
                load = 1'b1;
              else
                waiting_nxt = 1'b1;
            end
          end
        end
      end
`ifdef CRC8_FRAME_AUGMENT_EN
      ST_AUG: begin
        shift       = 1'b1;
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7)
          state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (crc_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over any handshake seen in the same cycle.
    if (abort) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = 3'd0;
      waiting_nxt = 1'b0;
      load        = 1'b0;
      frame_init  = 1'b0;
      shift       = 1'b0;
      s_ready     = 1'b0;
    end
  end

  crc8 u_crc8 (
    .clk     (clk),
    .rst     (rst | frame_init),
    .shift   (shift),
    .crc_bit (crc_bit),
    .result  (crc_data)
  );

  assign crc_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Directed bench for crc8_frame_ctrl: frame results, latency, hold, abort, reset.
// Follows CRC8_FRAME_AUGMENT_EN for expected latency and CRC values.
module tb_crc8_frame_ctrl;

`ifdef CRC8_FRAME_AUGMENT_EN
  localparam int         LAT     = 17;
  localparam logic [7:0] EXP_00  = 8'h68;
  localparam logic [7:0] EXP_0000 = 8'h6A;
  localparam logic [7:0] EXP_80  = 8'hDD;
`else
  localparam int         LAT     = 9;
  localparam logic [7:0] EXP_00  = 8'h26;
  localparam logic [7:0] EXP_0000 = 8'h68;
  localparam logic [7:0] EXP_80  = 8'hA6;
`endif

  logic       clk = 1'b0;
  logic       rst, s_valid, s_last, abort, crc_ready;
  logic [7:0] s_data;
  logic       s_ready, crc_valid, busy;
  logic [7:0] crc_data;

  int n_tests = 0;
  int n_fail  = 0;

  crc8_frame_ctrl #(.MSB_FIRST(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .abort     (abort),
    .crc_valid (crc_valid),
    .crc_ready (crc_ready),
    .crc_data  (crc_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a byte until accepted; n = cycles spent waiting for s_ready.
  task automatic send_byte(input logic [7:0] d, input logic last, output int n);
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #0;
    while (!s_ready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("accept_timeout", 32'(n), 32'd0);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Counts cycles from acceptance-cycle+1 until crc_valid, returns latency from acceptance.
  task automatic wait_crc(output int lat);
    lat = 1;
    while (!crc_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (lat >= 60) chk("crc_timeout", 32'(lat), 32'(LAT));
  endtask

  task automatic take_crc();
    crc_ready = 1'b1;
    tick();
    crc_ready = 1'b0;
  endtask

  initial begin
    int n, lat;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    abort = 1'b0; crc_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_crc_valid", 32'(crc_valid), 32'd0);
    chk("rst_crc_data", 32'(crc_data), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single zero byte.
    send_byte(8'h00, 1'b1, n);
    chk("one_mid_s_ready", 32'(s_ready), 32'd0);
    chk("one_busy", 32'(busy), 32'd1);
    repeat (6) tick();
    chk("one_bit7_s_ready", 32'(s_ready), 32'd0);
    lat = 7;
    while (!crc_valid && lat < 60) begin tick(); lat++; end
    chk("one_latency", 32'(lat), 32'(LAT));
    chk("one_crc", 32'(crc_data), 32'(EXP_00));
    take_crc();
    chk("one_idle", 32'(busy), 32'd0);

    // Back-to-back two zero bytes.
    send_byte(8'h00, 1'b0, n);
    send_byte(8'h00, 1'b1, n);
    chk("b2b_accept_cycle", 32'(n + 1), 32'd8);
    wait_crc(lat);
    chk("b2b_latency", 32'(lat), 32'(LAT));
    chk("b2b_crc", 32'(crc_data), 32'(EXP_0000));

    // Hold result with crc_ready low.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(crc_valid), 32'd1);
      chk("hold_data", 32'(crc_data), 32'(EXP_0000));
      chk("hold_s_ready", 32'(s_ready), 32'd0);
    end
    take_crc();
    chk("hold_after_busy", 32'(busy), 32'd0);
    chk("hold_after_valid", 32'(crc_valid), 32'd0);
    chk("hold_after_s_ready", 32'(s_ready), 32'd1);

    // Gap between bytes must not change the result.
    send_byte(8'h00, 1'b0, n);
    repeat (10) tick();
    chk("gap_wait_s_ready", 32'(s_ready), 32'd1);
    chk("gap_wait_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b1, n);
    wait_crc(lat);
    chk("gap_latency", 32'(lat), 32'(LAT));
    chk("gap_crc", 32'(crc_data), 32'(EXP_0000));
    take_crc();

    // Non-zero byte exercises bit ordering.
    send_byte(8'h80, 1'b1, n);
    wait_crc(lat);
    chk("msb_crc", 32'(crc_data), 32'(EXP_80));
    take_crc();

    // Abort during bit 4, then a clean frame must start from a re-initialised CRC.
    send_byte(8'h5A, 1'b1, n);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(crc_valid), 32'd0);
    send_byte(8'h00, 1'b1, n);
    wait_crc(lat);
    chk("abort_next_crc", 32'(crc_data), 32'(EXP_00));

    // Abort in DONE beats a simultaneous crc_ready and drops crc_valid.
    abort = 1'b1;
    crc_ready = 1'b1;
    tick();
    abort = 1'b0;
    crc_ready = 1'b0;
    chk("abort_done_valid", 32'(crc_valid), 32'd0);
    chk("abort_done_busy", 32'(busy), 32'd0);

    // Reset mid-shift.
    send_byte(8'hC3, 1'b0, n);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_valid", 32'(crc_valid), 32'd0);
    chk("midrst_crc", 32'(crc_data), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
